iperf_client_axis_stall_detector: RTL and testbench
===================================================

// Module: iperf_client_axis_stall_detector
// PURPOSE
// - Producer side of the deadlock-monitor axis_block_sigs bus: watches the TVALID/TREADY pair of
//   every AXI-Stream channel of the iperf_client dataflow region and flags each channel stalled
//   longer than a threshold.
// - Sits beside the dataflow instance; its axis_block_sigs output feeds the deadlock monitor tree.
// - Also latches the first channel to block, for debug readout.
// PARAMETERS
// - NUM_CH        12          number of monitored AXI-Stream channels
// - STALL_CYCLES  16          consecutive stall cycles before a channel reports blocked (>=2)
// - DIR_OUT       12'hF80     per-channel direction mask; 1 = process output (producer side), 0 = process input
// - CNT_W         $clog2(STALL_CYCLES+1)   stall counter width (derived, do not override)
// PORTS
// - clock            in   1          single clock for all logic
// - reset_n          in   1          asynchronous, active-low reset
// - monitor_en       in   1          1 = detection active; 0 = all channels held in IDLE
// - axis_tvalid      in   NUM_CH     observed TVALID per channel
// - axis_tready      in   NUM_CH     observed TREADY per channel
// - axis_block_sigs  out  NUM_CH     per-channel blocked flag (registered)
// - first_blk_vld    out  1          sticky: at least one channel has blocked since last clear
// - first_blk_ch     out  $clog2(NUM_CH)  index of the first channel that blocked
// - first_blk_clr    in   1          single-cycle pulse; clears first_blk_vld/first_blk_ch
// BEHAVIOUR
// - Reset: axis_block_sigs=0, first_blk_vld=0, first_blk_ch=0, all counters 0, all channels IDLE.
// - Stall condition per channel i:
//   - DIR_OUT[i]=1: tvalid & ~tready
//   - DIR_OUT[i]=0: tready & ~tvalid
//   - tvalid&tready (transfer) or ~tvalid&~tready (idle) is never a stall.
// - Per-channel FSM:
//   - IDLE -> STALLING when stall=1 (cnt<=1).
//   - STALLING: cnt increments each stall cycle; -> IDLE with cnt=0 when stall=0;
//     -> BLOCKED when cnt reaches STALL_CYCLES.
//   - BLOCKED: cnt holds (saturates at STALL_CYCLES); -> IDLE with cnt=0 on the first stall=0 cycle.
//   - axis_block_sigs[i] = (state==BLOCKED), registered.
// - Latency: if stall first holds in cycle c0 and persists, axis_block_sigs[i] rises in cycle
//   c0+STALL_CYCLES. It falls one cycle after the first non-stall cycle.
// - monitor_en=0: every channel forced to IDLE/cnt=0 on the next edge, outputs drop next cycle;
//   first_blk state is kept.
// - First-block capture:
//   - Updated in the cycle any channel enters BLOCKED while first_blk_vld=0: vld<=1, ch<=lowest
//     index among channels entering BLOCKED that cycle.
//   - Further blocks are ignored while vld=1.
//   - If first_blk_clr coincides with a new block, clear wins; capture retries on the next entry to BLOCKED.
// - reset_n assertion mid-stall clears everything immediately (async); no partial count survives.
// CONFIGURATION
// - Macro AXIS_STALL_STATS_EN:
//   - Defined: adds ports stat_sel (in, $clog2(NUM_CH)) and stat_count (out, 16).
//     Per-channel 16-bit event counter increments on each IDLE/STALLING->BLOCKED entry and
//     saturates at 16'hFFFF. stat_count = counter[stat_sel], registered (1-cycle latency).
//     Counters reset only by reset_n.
//   - Undefined: no extra ports, no counters; behaviour otherwise identical.
// STRUCTURE
// - Package iperf_client_deadlock_pkg:
//   - stall_state_t enum {ST_IDLE, ST_STALLING, ST_BLOCKED}
//   - function clog2_min1() for index widths
//   - localparam STAT_W=16
// - Sub-module iperf_client_axis_stall_chan: one channel's stall decode, FSM and counter; outputs
//   blocked and enter_blocked pulse.
// - Top: generate loop of NUM_CH instances, lowest-index priority encoder for first-block capture,
//   optional stats bank.
// TESTING
// - Ch0 (input): tready=1, tvalid=0 held 20 cycles, STALL_CYCLES=16 -> block_sigs[0] rises at cycle 16,
//   first_blk_vld=1, first_blk_ch=0.
// - Ch7 (output): 15 stall cycles, 1 transfer, 15 stall cycles -> block_sigs[7] never asserts.
// - Ch3 and ch9 start stalling on the same cycle -> both block at +16; first_blk_ch=3.
//   Then ch9 released -> block_sigs[9] falls next cycle, ch3 stays high.
// - Ch5 blocked, monitor_en 1->0 -> block_sigs[5]=0 next cycle, first_blk_vld stays 1;
//   first_blk_clr pulse -> vld=0, ch=0.
// - Ch2 stalling 10 cycles, reset_n pulsed low -> all outputs 0 immediately.
//   After release, a fresh 16-cycle stall is required before block_sigs[2]=1.
// - With AXIS_STALL_STATS_EN: ch4 blocked 3 separate times, stat_sel=4 -> stat_count=3 one cycle later.

Source files
------------

// File: rtl/iperf_client_deadlock_pkg.sv
// Shared types and helpers for the iperf_client deadlock-monitor producers.
package iperf_client_deadlock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STALLING = 2'd1,
    ST_BLOCKED  = 2'd2
  } stall_state_t;

  localparam int STAT_W = 16;

  // Index width that never collapses to zero bits for a single-entry vector.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/iperf_client_axis_stall_chan.sv
// One AXI-Stream channel: stall decode, IDLE/STALLING/BLOCKED FSM and consecutive-stall counter.
//   state       | meaning
//   ST_IDLE     | no stall in progress, cnt=0
//   ST_STALLING | stall seen for cnt consecutive cycles, below threshold
//   ST_BLOCKED  | stalled STALL_CYCLES or more cycles, cnt saturated
module iperf_client_axis_stall_chan
  import iperf_client_deadlock_pkg::*;
#(
  parameter int STALL_CYCLES = 16,
  parameter bit DIR_OUT      = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic monitor_en,
  input  logic tvalid,
  input  logic tready,
  output logic blocked,
  output logic enter_blocked
);

  localparam int CNT_W = $clog2(STALL_CYCLES + 1);

  localparam logic [1:0] S_IDLE     = 2'(ST_IDLE);
  localparam logic [1:0] S_STALLING = 2'(ST_STALLING);
  localparam logic [1:0] S_BLOCKED  = 2'(ST_BLOCKED);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall;

  // Producer side waits on the consumer's TREADY; consumer side waits on upstream TVALID.
  assign stall = DIR_OUT ? (tvalid & ~tready) : (tready & ~tvalid);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    enter_blocked = 1'b0;
    if (!monitor_en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (stall) begin
            state_d = S_STALLING;
            cnt_d   = CNT_W'(1);
          end
        end
        S_STALLING: begin
          if (!stall) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(STALL_CYCLES - 1)) begin
            state_d       = S_BLOCKED;
            cnt_d         = CNT_W'(STALL_CYCLES);
            enter_blocked = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_BLOCKED: begin
          if (!stall) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign blocked = (state_q == S_BLOCKED);

endmodule

// File: rtl/iperf_client_axis_stall_detector.sv
// Per-channel AXI-Stream stall detector feeding axis_block_sigs, with first-block capture.
// Optional per-channel block-event counters when AXIS_STALL_STATS_EN is defined.
module iperf_client_axis_stall_detector
  import iperf_client_deadlock_pkg::*;
#(
  parameter int                 NUM_CH       = 12,
  parameter int                 STALL_CYCLES = 16,
  parameter logic [NUM_CH-1:0]  DIR_OUT      = 12'hF80
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            monitor_en,
  input  logic [NUM_CH-1:0]               axis_tvalid,
  input  logic [NUM_CH-1:0]               axis_tready,
  output logic [NUM_CH-1:0]               axis_block_sigs,
  output logic                            first_blk_vld,
  output logic [clog2_min1(NUM_CH)-1:0]   first_blk_ch,
`ifdef AXIS_STALL_STATS_EN
  input  logic [clog2_min1(NUM_CH)-1:0]   stat_sel,
  output logic [STAT_W-1:0]               stat_count,
`endif
  input  logic                            first_blk_clr
);

  localparam int IDX_W = clog2_min1(NUM_CH);

  logic [NUM_CH-1:0] enter_blocked;
  logic [IDX_W-1:0]  enter_idx;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    iperf_client_axis_stall_chan #(
      .STALL_CYCLES (STALL_CYCLES),
      .DIR_OUT      (DIR_OUT[i])
    ) u_chan (
      .clock         (clock),
      .reset_n       (reset_n),
      .monitor_en    (monitor_en),
      .tvalid        (axis_tvalid[i]),
      .tready        (axis_tready[i]),
      .blocked       (axis_block_sigs[i]),
      .enter_blocked (enter_blocked[i])
    );
  end

  // Downward scan so the lowest index entering BLOCKED wins.
  always_comb begin
    enter_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (enter_blocked[i]) enter_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      first_blk_vld <= 1'b0;
      first_blk_ch  <= '0;
    end else if (first_blk_clr) begin
      first_blk_vld <= 1'b0;
      first_blk_ch  <= '0;
    end else if (!first_blk_vld && (|enter_blocked)) begin
      first_blk_vld <= 1'b1;
      first_blk_ch  <= enter_idx;
    end
  end

`ifdef AXIS_STALL_STATS_EN
  logic [STAT_W-1:0] stat_cnt_q [NUM_CH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) stat_cnt_q[i] <= '0;
      stat_count <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (enter_blocked[i] && (stat_cnt_q[i] != {STAT_W{1'b1}}))
          stat_cnt_q[i] <= stat_cnt_q[i] + STAT_W'(1);
      end
      if (int'(stat_sel) < NUM_CH) stat_count <= stat_cnt_q[stat_sel];
      else                         stat_count <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_iperf_client_axis_stall_detector.sv
// Directed table-driven bench for iperf_client_axis_stall_detector (NUM_CH=12, STALL_CYCLES=16).
module tb_iperf_client_axis_stall_detector;
  import iperf_client_deadlock_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        monitor_en = 1'b0;
  logic [11:0] axis_tvalid = '0;
  logic [11:0] axis_tready = '0;
  logic [11:0] axis_block_sigs;
  logic        first_blk_vld;
  logic [3:0]  first_blk_ch;
  logic        first_blk_clr = 1'b0;
`ifdef AXIS_STALL_STATS_EN
  logic [3:0]  stat_sel = '0;
  logic [15:0] stat_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  iperf_client_axis_stall_detector dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .monitor_en      (monitor_en),
    .axis_tvalid     (axis_tvalid),
    .axis_tready     (axis_tready),
    .axis_block_sigs (axis_block_sigs),
    .first_blk_vld   (first_blk_vld),
    .first_blk_ch    (first_blk_ch),
`ifdef AXIS_STALL_STATS_EN
    .stat_sel        (stat_sel),
    .stat_count      (stat_count),
`endif
    .first_blk_clr   (first_blk_clr)
  );

  typedef struct {
    logic        en;
    logic [11:0] tv;
    logic [11:0] tr;
    logic        clr;
    int          n;
    logic [11:0] exp_blk;
    logic        exp_vld;
    logic [3:0]  exp_ch;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, input logic [11:0] tv, input logic [11:0] tr,
                     input logic clr, input int n, input logic [11:0] eb,
                     input logic ev, input logic [3:0] ec, input string name);
    vec_t v;
    v.en = en; v.tv = tv; v.tr = tr; v.clr = clr; v.n = n;
    v.exp_blk = eb; v.exp_vld = ev; v.exp_ch = ec; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [11:0] eb, input logic ev,
                         input logic [3:0] ec);
    chk({name, ".blk"}, 32'(axis_block_sigs), 32'(eb));
    chk({name, ".vld"}, 32'(first_blk_vld), 32'(ev));
    chk({name, ".ch"},  32'(first_blk_ch), 32'(ec));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    // ch0 input side: tready without tvalid
    add(1, 12'h000, 12'h001, 0, 15, 12'h000, 0, 0, "ch0_pre");
    add(1, 12'h000, 12'h001, 0,  1, 12'h001, 1, 0, "ch0_block");
    add(1, 12'h000, 12'h001, 0,  4, 12'h001, 1, 0, "ch0_hold");
    add(1, 12'h000, 12'h000, 0,  1, 12'h000, 1, 0, "ch0_release");
    add(1, 12'h000, 12'h000, 1,  1, 12'h000, 0, 0, "clr_a");
    // ch7 output side: a single transfer restarts the count
    add(1, 12'h080, 12'h000, 0, 15, 12'h000, 0, 0, "ch7_stall15a");
    add(1, 12'h080, 12'h080, 0,  1, 12'h000, 0, 0, "ch7_xfer");
    add(1, 12'h080, 12'h000, 0, 15, 12'h000, 0, 0, "ch7_stall15b");
    add(1, 12'h080, 12'h000, 0,  1, 12'h080, 1, 7, "ch7_stall16");
    add(1, 12'h000, 12'h000, 0,  1, 12'h000, 1, 7, "ch7_release");
    add(1, 12'h000, 12'h000, 1,  1, 12'h000, 0, 0, "clr_b");
    // ch3 (input) and ch9 (output) together
    add(1, 12'h200, 12'h008, 0, 15, 12'h000, 0, 0, "ch3_9_pre");
    add(1, 12'h200, 12'h008, 0,  1, 12'h208, 1, 3, "ch3_9_block");
    add(1, 12'h000, 12'h008, 0,  1, 12'h008, 1, 3, "ch9_release");
    add(1, 12'h000, 12'h008, 0,  5, 12'h008, 1, 3, "ch3_hold");
    add(1, 12'h000, 12'h000, 0,  1, 12'h000, 1, 3, "ch3_release");
    add(1, 12'h000, 12'h000, 1,  1, 12'h000, 0, 0, "clr_c");
    // clear coinciding with a block entry, then capture retries on ch6
    add(1, 12'h000, 12'h002, 0, 15, 12'h000, 0, 0, "ch1_pre");
    add(1, 12'h000, 12'h002, 1,  1, 12'h002, 0, 0, "clr_wins");
    add(1, 12'h000, 12'h042, 0, 15, 12'h002, 0, 0, "ch6_pre");
    add(1, 12'h000, 12'h042, 0,  1, 12'h042, 1, 6, "ch6_retry");
    add(1, 12'h000, 12'h000, 0,  1, 12'h000, 1, 6, "ch1_6_release");
    add(1, 12'h000, 12'h000, 1,  1, 12'h000, 0, 0, "clr_d");
    // ch5 with monitor_en dropped
    add(1, 12'h000, 12'h020, 0, 16, 12'h020, 1, 5, "ch5_block");
    add(0, 12'h000, 12'h020, 0,  1, 12'h000, 1, 5, "en_off");
    add(0, 12'h000, 12'h020, 0, 20, 12'h000, 1, 5, "en_off_hold");
    add(0, 12'h000, 12'h020, 1,  1, 12'h000, 0, 0, "clr_en_off");
    add(1, 12'h000, 12'h020, 0, 15, 12'h000, 0, 0, "en_on_pre");
    add(1, 12'h000, 12'h020, 0,  1, 12'h020, 1, 5, "en_on_block");
    add(1, 12'h000, 12'h000, 0,  1, 12'h000, 1, 5, "ch5_release");
    add(1, 12'h000, 12'h000, 1,  1, 12'h000, 0, 0, "clr_e");

    #2 reset_n = 1'b0;
    step(3);
    chk_all("reset", 12'h000, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;

    foreach (vecs[k]) begin
      monitor_en    = vecs[k].en;
      axis_tvalid   = vecs[k].tv;
      axis_tready   = vecs[k].tr;
      first_blk_clr = vecs[k].clr;
      step(vecs[k].n);
      first_blk_clr = 1'b0;
      chk_all(vecs[k].name, vecs[k].exp_blk, vecs[k].exp_vld, vecs[k].exp_ch);
    end

    // Async reset mid-stall: ch11 blocked, ch2 ten cycles into a stall
    monitor_en  = 1'b1;
    axis_tvalid = 12'h800;
    axis_tready = 12'h000;
    step(16);
    chk_all("ch11_block", 12'h800, 1, 11);
    axis_tready = 12'h004;
    step(10);
    chk_all("ch2_stall10", 12'h800, 1, 11);
    reset_n = 1'b0;
    #1;
    chk_all("async_reset", 12'h000, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    step(15);
    chk_all("post_reset15", 12'h000, 0, 0);
    step(1);
    chk_all("post_reset16", 12'h804, 1, 2);
    axis_tvalid = '0;
    axis_tready = '0;
    step(1);
    first_blk_clr = 1'b1;
    step(1);
    first_blk_clr = 1'b0;
    chk_all("clr_f", 12'h000, 0, 0);

`ifdef AXIS_STALL_STATS_EN
    for (int r = 0; r < 3; r++) begin
      axis_tready = 12'h010;
      step(16);
      chk($sformatf("ch4_block%0d", r), 32'(axis_block_sigs), 32'h010);
      axis_tready = 12'h000;
      step(1);
    end
    stat_sel = 4'd4;
    step(1);
    chk("stat_ch4", 32'(stat_count), 32'd3);
    stat_sel = 4'd2;
    step(1);
    chk("stat_ch2", 32'(stat_count), 32'd1);
    stat_sel = 4'd0;
    step(1);
    chk("stat_ch0", 32'(stat_count), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
